// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Control stage sitting directly upstream of the ALU. It owns the A and B
// operand registers and produces the ALU's subtract select, its active-low
// bus-assert enables and its posedge flag triggers. Commands arrive one at a
// time over a valid/ready handshake. Each command is sequenced through
// DRIVE/CAPTURE cycles, and the ALU result is written from the data bus back
// into A. The carry and shift flags live inside the ALU; this block only
// strobes them.
//
// Optional feature macro: ALU_SEQ_SHRN_EN
//   When defined, opcode 7 is SHRN. It performs cmd_imm[2:0] repeated
//   right-shift passes.
//   When undefined, opcode 7 behaves as a NOP and no pass counter exists.
//
// Ports
//   clk         in   system clock, all state on rising edge
//   reset       in   asynchronous active-high reset (shared with the ALU)
//   cmd_valid   in   command present
//   cmd_ready   out  high only while idle (combinational from state)
//   cmd_op      in   [2:0] opcode: NOP LDA LDB ADD SUB SHR CMP SHRN
//   cmd_imm     in   [7:0] immediate / shift count
//   dbus        in   [7:0] shared data bus, read while an ALU output drives it
//   areg        out  [7:0] A operand to ALU
//   breg        out  [7:0] B operand to ALU
//   doSubtract  out  ALU subtract select
//   assertBarE  out  active-low: ALU drives add/sub result onto dbus
//   assertBarS  out  active-low: ALU drives shifted A onto dbus
//   triggerC    out  rising edge captures ALU carry
//   triggerS    out  rising edge captures ALU shift bit
//   done        out  one-cycle pulse, command complete
// -----------------------------------------------------------------------------
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_imm,
  input  logic [7:0] dbus,
  output logic [7:0] areg,
  output logic [7:0] breg,
  output logic       doSubtract,
  output logic       assertBarE,
  output logic       assertBarS,
  output logic       triggerC,
  output logic       triggerS,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LDA  = 3'd1,
    OP_LDB  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_SHR  = 3'd5,
    OP_CMP  = 3'd6,
    OP_SHRN = 3'd7
  } op_t;

  state_t     r_state;
  state_t     w_next_state;
  op_t        r_op;
  op_t        w_op;
  logic [7:0] r_areg;
  logic [7:0] r_breg;
  logic       r_sub;
  logic       r_bar_e;
  logic       r_bar_s;
  logic       r_trig_c;
  logic       r_trig_s;
  logic       r_done;

  logic w_accept;
  logic w_use_e;
  logic w_use_s;
  logic w_sub;
  logic w_alu_cmd;
  logic w_last_pass;
  logic w_busy_next;

`ifdef ALU_SEQ_SHRN_EN
  logic [2:0] r_cnt;
`endif

  assign cmd_ready  = (r_state == S_IDLE);
  assign areg       = r_areg;
  assign breg       = r_breg;
  assign doSubtract = r_sub;
  assign assertBarE = r_bar_e;
  assign assertBarS = r_bar_s;
  assign triggerC   = r_trig_c;
  assign triggerS   = r_trig_s;
  assign done       = r_done;

  // Next-state logic and per-command decode.
  // The registered outputs are derived from the state being entered. This
  // way each output is already valid for the whole cycle it belongs to.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned (which would infer a latch).
    w_next_state = r_state;
    w_accept     = (r_state == S_IDLE) && cmd_valid;
    // While idle, decode the incoming opcode; otherwise use the latched one.
    w_op         = w_accept ? op_t'(cmd_op) : r_op;
    w_use_e      = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_CMP);
    w_sub        = (w_op == OP_SUB) || (w_op == OP_CMP);
`ifdef ALU_SEQ_SHRN_EN
    w_use_s      = (w_op == OP_SHR) || (w_op == OP_SHRN);
    // A zero-count SHRN takes the short NOP path.
    w_alu_cmd    = w_use_e || (w_op == OP_SHR) ||
                   ((w_op == OP_SHRN) && (cmd_imm[2:0] != 3'd0));
    w_last_pass  = (r_op != OP_SHRN) || (r_cnt <= 3'd1);
`else
    w_use_s      = (w_op == OP_SHR);
    w_alu_cmd    = w_use_e || w_use_s;
    w_last_pass  = 1'b1;
`endif

    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = w_alu_cmd ? S_DRIVE : S_DONE;
      S_DRIVE:   w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = w_last_pass ? S_DONE : S_DRIVE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase

    w_busy_next = (w_next_state == S_DRIVE) || (w_next_state == S_CAPTURE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_areg   <= 8'h00;
      r_breg   <= 8'h00;
      r_sub    <= 1'b0;
      r_bar_e  <= 1'b1;
      r_bar_s  <= 1'b1;
      r_trig_c <= 1'b0;
      r_trig_s <= 1'b0;
      r_done   <= 1'b0;
`ifdef ALU_SEQ_SHRN_EN
      r_cnt    <= 3'd0;
`endif
    end else begin
      r_state  <= w_next_state;
      r_sub    <= w_busy_next && w_sub;
      r_bar_e  <= !(w_busy_next && w_use_e);
      r_bar_s  <= !(w_busy_next && w_use_s);
      // Trigger rises on entry to CAPTURE, while A/B are still the operands.
      r_trig_c <= (w_next_state == S_CAPTURE) && w_use_e;
      r_trig_s <= (w_next_state == S_CAPTURE) && w_use_s;
      r_done   <= (w_next_state == S_DONE);

      if (w_accept) begin
        r_op <= op_t'(cmd_op);
        if (op_t'(cmd_op) == OP_LDA) r_areg <= cmd_imm;
        if (op_t'(cmd_op) == OP_LDB) r_breg <= cmd_imm;
`ifdef ALU_SEQ_SHRN_EN
        r_cnt <= cmd_imm[2:0];
`endif
      end

      // The result comes from the bus on CAPTURE exit; CMP only wants the flag.
      if (r_state == S_CAPTURE) begin
        if (r_op != OP_CMP) r_areg <= dbus;
`ifdef ALU_SEQ_SHRN_EN
        if (r_op == OP_SHRN) r_cnt <= r_cnt - 3'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Bench for alu_sequencer. A small stand-in ALU drives dbus and holds the carry
// and shift flags. A command-level model predicts every output on every cycle
// from "cycles since accept". Directed commands carry hand-computed results.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic [7:0] dbus;
  logic [7:0] areg;
  logic [7:0] breg;
  logic       doSubtract;
  logic       assertBarE;
  logic       assertBarS;
  logic       triggerC;
  logic       triggerS;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_imm    (cmd_imm),
    .dbus       (dbus),
    .areg       (areg),
    .breg       (breg),
    .doSubtract (doSubtract),
    .assertBarE (assertBarE),
    .assertBarS (assertBarS),
    .triggerC   (triggerC),
    .triggerS   (triggerS),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stand-in ALU ----------------
  // The shift flag holds the A[0] captured on triggerS. The ALU shifts that
  // bit into A[7].
  logic alu_carry;
  logic alu_fs;

  always_comb begin
    if (!assertBarE)      dbus = doSubtract ? areg - breg : areg + breg;
    else if (!assertBarS) dbus = {alu_fs, areg[7:1]};
    else                  dbus = 8'hA5;
  end

  always @(posedge triggerC or posedge reset)
    if (reset) alu_carry <= 1'b0;
    else       alu_carry <= doSubtract ? (areg >= breg)
                                       : (({1'b0, areg} + {1'b0, breg}) > 9'd255);

  always @(posedge triggerS or posedge reset)
    if (reset) alu_fs <= 1'b0;
    else       alu_fs <= areg[0];

  // ---------------- command-level model ----------------
  function automatic int busy_len(input logic [2:0] op, input logic [7:0] imm);
    if (op >= 3'd3 && op <= 3'd6) return 2;
`ifdef ALU_SEQ_SHRN_EN
    if (op == 3'd7) return 2 * int'(imm[2:0]);
`endif
    return 0;
  endfunction

  function automatic logic is_e(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4) || (op == 3'd6);
  endfunction

  function automatic logic is_s(input logic [2:0] op);
`ifdef ALU_SEQ_SHRN_EN
    return (op == 3'd5) || (op == 3'd7);
`else
    return (op == 3'd5);
`endif
  endfunction

  int         m_k;    // 0 = idle, else cycle number since accept
  int         m_len;  // number of busy (drive/capture) cycles
  logic [2:0] m_op;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_carry;
  logic       m_fs;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_k <= 0; m_len <= 0; m_op <= 3'd0; m_a <= 8'h00; m_b <= 8'h00;
      m_carry <= 1'b0; m_fs <= 1'b0;
    end else if (m_k == 0) begin
      if (cmd_valid) begin
        m_op  <= cmd_op;
        m_len <= busy_len(cmd_op, cmd_imm);
        m_k   <= 1;
        if (cmd_op == 3'd1) m_a <= cmd_imm;
        if (cmd_op == 3'd2) m_b <= cmd_imm;
      end
    end else begin
      // Entering a capture cycle: flags see the unmodified operands.
      if (m_k <= m_len && (m_k % 2) == 1) begin
        if (is_e(m_op)) m_carry <= (m_op == 3'd3) ? ((int'(m_a) + int'(m_b)) > 255) : (m_a >= m_b);
        if (is_s(m_op)) m_fs <= m_a[0];
      end
      // Leaving a capture cycle: write back.
      if (m_k <= m_len && (m_k % 2) == 0) begin
        case (m_op)
          3'd3:       m_a <= m_a + m_b;
          3'd4:       m_a <= m_a - m_b;
          3'd5, 3'd7: m_a <= {m_fs, m_a[7:1]};
          default:    ;
        endcase
      end
      m_k <= (m_k >= m_len + 1) ? 0 : m_k + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic busy;
    logic cap;
    busy = (m_k >= 1) && (m_k <= m_len);
    cap  = busy && ((m_k % 2) == 0);
    check("cmd_ready",  cmd_ready,  m_k == 0);
    check("areg",       areg,       m_a);
    check("breg",       breg,       m_b);
    check("assertBarE", assertBarE, !(busy && is_e(m_op)));
    check("assertBarS", assertBarS, !(busy && is_s(m_op)));
    check("doSubtract", doSubtract, busy && (m_op == 3'd4 || m_op == 3'd6));
    check("triggerC",   triggerC,   cap && is_e(m_op));
    check("triggerS",   triggerS,   cap && is_s(m_op));
    check("done",       done,       (m_k != 0) && (m_k == m_len + 1));
    check("alu_carry",  alu_carry,  m_carry);
    check("alu_fs",     alu_fs,     m_fs);
    check("bar_exclusive", assertBarE | assertBarS, 1'b1);
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int cyc;
    int n_e;
    int n_s;
    int n_tc;
    int n_ts;
    int n_sub;
  } res_t;

  // Issues one command from idle and measures its timeline. cyc = 0 means
  // done was never seen.
  task automatic issue(input logic [2:0] op, input logic [7:0] imm, output res_t r);
    r = '{0, 0, 0, 0, 0, 0};
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!assertBarE) r.n_e++;
      if (!assertBarS) r.n_s++;
      if (triggerC)    r.n_tc++;
      if (triggerS)    r.n_ts++;
      if (doSubtract)  r.n_sub++;
      if (done) begin
        r.cyc = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    res_t r;
    logic [7:0] exp_a;
    int n_done;

    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_imm = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_areg", areg, 8'h00);
    check("rst_breg", breg, 8'h00);
    check("rst_barE", assertBarE, 1'b1);
    check("rst_barS", assertBarS, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    reset = 1'b0;

    // 5 + 3
    issue(3'd1, 8'd5, r); check("lda_done_cyc", r.cyc, 1);
    issue(3'd2, 8'd3, r); check("ldb_done_cyc", r.cyc, 1);
    issue(3'd3, 8'd0, r);
    check("add_done_cyc", r.cyc, 3);
    check("add_barE_cycles", r.n_e, 2);
    check("add_trigC_cycles", r.n_tc, 1);
    check("add_areg", areg, 8'd8);
    check("add_carry", alu_carry, 1'b0);

    // 200 + 100 wraps to 44 with carry
    issue(3'd1, 8'd200, r);
    issue(3'd2, 8'd100, r);
    issue(3'd3, 8'd0, r);
    check("add_wrap_areg", areg, 8'd44);
    check("add_wrap_carry", alu_carry, 1'b1);

    // 3 - 5 = 254, borrow
    issue(3'd1, 8'd3, r);
    issue(3'd2, 8'd5, r);
    issue(3'd4, 8'd0, r);
    check("sub_areg", areg, 8'd254);
    check("sub_carry", alu_carry, 1'b0);
    check("sub_dosub_cycles", r.n_sub, 2);
    check("sub_done_cyc", r.cyc, 3);

    // CMP 9,9: A unchanged, carry set
    issue(3'd1, 8'd9, r);
    issue(3'd2, 8'd9, r);
    issue(3'd6, 8'd0, r);
    check("cmp_areg", areg, 8'd9);
    check("cmp_carry", alu_carry, 1'b1);
    check("cmp_trigC_cycles", r.n_tc, 1);
    check("cmp_barS_cycles", r.n_s, 0);

    // SHR 0x80 -> 0x40
    issue(3'd1, 8'h80, r);
    issue(3'd5, 8'd0, r);
    check("shr_areg", areg, 8'h40);
    check("shr_trigS_cycles", r.n_ts, 1);
    check("shr_barE_cycles", r.n_e, 0);
    check("shr_done_cyc", r.cyc, 3);

    // opcode 7, count 3
    issue(3'd1, 8'h80, r);
    issue(3'd7, 8'd3, r);
`ifdef ALU_SEQ_SHRN_EN
    exp_a = 8'h10;
    check("shrn_done_cyc", r.cyc, 7);
    check("shrn_trigS_cycles", r.n_ts, 3);
`else
    exp_a = 8'h80;
    check("op7_done_cyc", r.cyc, 1);
    check("op7_trigS_cycles", r.n_ts, 0);
`endif
    check("op7_areg", areg, exp_a);

    // opcode 7 with count 0, then NOP: both short, A untouched
    issue(3'd7, 8'd0, r);
    check("op7_zero_done_cyc", r.cyc, 1);
    check("op7_zero_areg", areg, exp_a);
    issue(3'd0, 8'hFF, r);
    check("nop_done_cyc", r.cyc, 1);
    check("nop_areg", areg, exp_a);

    // Reset during CAPTURE of ADD 5+3
    issue(3'd1, 8'd5, r);
    issue(3'd2, 8'd3, r);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_imm = 8'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_trigC", triggerC, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("mid_reset_areg", areg, 8'h00);
    check("mid_reset_breg", breg, 8'h00);
    check("mid_reset_barE", assertBarE, 1'b1);
    check("mid_reset_trigC", triggerC, 1'b0);
    check("mid_reset_ready", cmd_ready, 1'b1);
    check("mid_reset_done", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("post_reset_no_done", n_done, 0);
    @(posedge clk); #1;

    // Valid held high with a changing opcode during ADD
    issue(3'd1, 8'd5, r);
    issue(3'd2, 8'd3, r);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_imm = 8'd0;
    @(posedge clk); #1;
    cmd_op = 3'd2; cmd_imm = 8'd1;
    @(negedge clk); check("b2b_ready_c1", cmd_ready, 1'b0);
    @(posedge clk); #1;
    cmd_op = 3'd4;
    @(negedge clk); check("b2b_ready_c2", cmd_ready, 1'b0);
    @(posedge clk); #1;
    cmd_op = 3'd1; cmd_imm = 8'd99;
    @(negedge clk);
    check("b2b_ready_c3", cmd_ready, 1'b0);
    check("b2b_done_c3", done, 1'b1);
    check("b2b_areg_c3", areg, 8'd8);
    @(posedge clk); #1;
    cmd_imm = 8'd77;
    @(negedge clk); check("b2b_ready_c4", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_areg_c5", areg, 8'd77);
    check("b2b_breg_c5", breg, 8'd3);
    check("b2b_done_c5", done, 1'b1);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven control stage directly upstream of the ALU: owns the A and B operand registers and generates the ALU's subtract select, active-low bus-assert enables and posedge flag triggers. It accepts one command at a time over a valid/ready handshake, sequences the ALU through drive/capture cycles, and writes the ALU result from the data bus back into A. Flag registers (carry, shift) remain inside the ALU; this block only strobes them.

## Interface
Parameters: none.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; same net as the ALU's reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE; command accepted on clk edge with cmd_valid && cmd_ready
- cmd_op  in  3  opcode (see Operation)
- cmd_imm  in  8  immediate / shift count
- dbus  in  8  shared data bus, read while an ALU output is asserted
- areg  out  8  A operand register to ALU
- breg  out  8  B operand register to ALU
- doSubtract  out  1  ALU subtract select
- assertBarE  out  1  active-low: ALU drives add/sub result onto dbus
- assertBarS  out  1  active-low: ALU drives shifted A onto dbus
- triggerC  out  1  rising edge captures ALU carry
- triggerS  out  1  rising edge captures ALU shift bit
- done  out  1  one-cycle pulse: command complete, A/B final

## Operation
- States: IDLE, DRIVE, CAPTURE, DONE. All outputs registered except cmd_ready (= state==IDLE).
- Opcodes: 0 NOP; 1 LDA (A<=imm); 2 LDB (B<=imm); 3 ADD (A<=A+B); 4 SUB (A<=A-B); 5 SHR (A<={flagShift,A[7:1]}); 6 CMP (SUB, carry captured, A unchanged); 7 SHRN (see Configuration).
- NOP/LDA/LDB: register written on accept edge; IDLE->DONE->IDLE.
- ADD/SUB/CMP: IDLE->DRIVE->CAPTURE->DONE->IDLE. assertBarE low in DRIVE and CAPTURE; doSubtract = 1 for SUB/CMP, held through both; triggerC high only in CAPTURE; A<=dbus on the CAPTURE->DONE edge (not for CMP).
- SHR: same path with assertBarS low and triggerS instead; doSubtract 0.
- Arithmetic 8-bit, wraps mod 256; result is taken from dbus, never computed locally.
- Outside DRIVE/CAPTURE: assertBarE=assertBarS=1, triggers 0, doSubtract 0. Never both assertBar low.
- cmd_valid/cmd_op/cmd_imm ignored while not IDLE; no queuing.
- Reset (any time, incl. mid-command): state IDLE, areg=breg=0, assertBarE=assertBarS=1, doSubtract=0, triggerC=triggerS=0, done=0, shift counter 0. In-flight command is dropped; no trigger edge generated by reset.

## Timing
- Accept at edge e0. Load/NOP: done high in cycle 1 after e0.
- ALU op: DRIVE cycle 1, CAPTURE cycle 2, done high cycle 3; cmd_ready high again cycle 4. Back-to-back commands: one per 4 cycles.
- Trigger rises at start of CAPTURE while A/B still stable; A updates one edge later, so flag captures pre-update operands.
- dbus must be stable from DRIVE through the CAPTURE->DONE edge.

## Configuration
- ALU_SEQ_SHRN_EN defined: opcode 7 = SHRN, n = cmd_imm[2:0] latched on accept. n=0: behaves as NOP. n>0: n repetitions of DRIVE/CAPTURE (SHR behaviour each, triggerS pulsed each CAPTURE, A<=dbus each pass), then DONE; done in cycle 2n+1 after accept. Counter decrements on each CAPTURE exit.
- Not defined: opcode 7 behaves as NOP (done in cycle 1, A/B unchanged); no counter logic present.

## Test plan
- Reset, then LDA 5, LDB 3, ADD -> areg=8, ALU carry 0, done in cycle 3 after accept, assertBarE low exactly cycles 1-2.
- LDA 200, LDB 100, ADD -> areg=44, carry 1; then SUB with A=3, B=5 -> areg=254, doSubtract high cycles 1-2, carry 0.
- LDA 9, LDB 9, CMP -> areg stays 9, carry 1, triggerC single pulse in cycle 2, assertBarS never low.
- With ALU_SEQ_SHRN_EN, A=0x80, flagShift 0, SHRN imm=3 -> areg=0x10, three triggerS pulses, done in cycle 7; imm=0 -> done cycle 1, A unchanged; macro off -> op 7 done cycle 1, A unchanged.
- Assert reset during CAPTURE of ADD (A=5, B=3) -> immediately areg=0, breg=0, assertBarE=1, triggerC=0, cmd_ready=1, no done pulse.
- Hold cmd_valid high with changing cmd_op during an ADD -> only first command executed; second accepted only in cycle 4.
